csa_seq_ctrl: RTL and testbench

Sequencing controller for the carry-select adder datapath. It accepts a WIDTH-bit operand pair over a valid/ready handshake and walks the addition one SLICE-bit slice per cycle. For each slice it forms both candidate sums (carry-in 0 and carry-in 1) and selects between them with the registered carry, mirroring the mux-select stage of the carry-select adder. It then presents the full result and carry-out on a valid/ready output port. It sits between an operand source (test sequencer or register file) and the result consumer in the 8-bit CSA design.

---
 rtl/csa_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_csa_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_ctrl.sv
// csa_seq_ctrl: sequencing controller for the carry-select adder datapath.
// Accepts a WIDTH-bit operand pair plus carry-in over valid/ready. It then
// adds one SLICE-bit slice per cycle. Each slice forms both candidate sums
// and the registered carry selects between them. The full result and
// carry-out are presented on a valid/ready output port.
// Optional feature: define CSA_OVF_EN to add the registered signed-overflow
// output ovf.

module csa_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CSA_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // BUSY  | one slice added per cycle, busy high
  // DONE  | result held, out_valid high until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE:0]   s0;
  logic [SLICE:0]   s1;
  logic [SLICE:0]   s_sel;
  logic             last_slice;

  assign a_s        = a_q[idx*SLICE +: SLICE];
  assign b_s        = b_q[idx*SLICE +: SLICE];
  assign s0         = {1'b0, a_s} + {1'b0, b_s};
  assign s1         = s0 + {{SLICE{1'b0}}, 1'b1};
  assign s_sel      = carry_q ? s1 : s0;
  assign last_slice = (idx == LAST_IDX);

  // All handshake outputs decode registered state only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign cout      = carry_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = BUSY;
      BUSY:    if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice carry-select add and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          idx     <= '0;
        end
        BUSY: begin
          sum[idx*SLICE +: SLICE] <= s_sel[SLICE-1:0];
          carry_q                 <= s_sel[SLICE];
          idx                     <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_OVF_EN
  // Carry into the MSB is recovered as a^b^sum at that bit position.
  // Overflow is that carry XOR the carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (state == BUSY && last_slice)
      ovf <= (a_s[SLICE-1] ^ b_s[SLICE-1] ^ s_sel[SLICE-1]) ^ s_sel[SLICE];
  end
`endif

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Testbench for csa_seq_ctrl (default WIDTH=8, SLICE=4).
// Expected results are queued at accept and compared when the DUT hands them off.

module tb_csa_seq_ctrl;

  localparam int N = 2;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
`ifdef CSA_OVF_EN
  logic       ovf;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  csa_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef CSA_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check("sum",  32'(sum),  32'(mon_e.sum));
        check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef CSA_OVF_EN
        check("ovf",  32'(ovf),  32'(mon_e.ovf));
`endif
      end
    end
  end

  // One full transaction; entered and left at posedge+1 with the DUT in IDLE.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input int stall);
    exp_t       e;
    logic [8:0] full;
    int         edges;
    full   = {1'b0, ta} + {1'b0, tb_v} + {8'h00, tc};
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = (ta[7] == tb_v[7]) && (full[7] != ta[7]);
    check("in_ready_idle", 32'(in_ready), 32'(1));
    out_ready = (stall == 0);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'(1));
    check("in_ready_busy", 32'(in_ready), 32'(0));
    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency", 32'(edges), 32'(N));
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) begin
          in_valid = 1'b1; a = 8'h11; b = 8'h11;
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        check("stall_out_valid", 32'(out_valid), 32'(1));
        check("stall_sum",       32'(sum),       32'(e.sum));
        check("stall_cout",      32'(cout),      32'(e.cout));
        check("stall_in_ready",  32'(in_ready),  32'(0));
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_hs",  32'(in_ready),  32'(1));
    check("out_valid_after_hs", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_sum",       32'(sum),       32'(0));
    check("rst_cout",      32'(cout),      32'(0));
`ifdef CSA_OVF_EN
    check("rst_ovf",       32'(ovf),       32'(0));
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(8'h0F, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'h00, 1'b1, 0);
    do_op(8'hA5, 8'h5A, 1'b0, 0);
    do_op(8'h12, 8'h34, 1'b1, 5);

    // Abort after slice 0 of 3C+3C; nothing may come out.
    a = 8'h3C; b = 8'h3C; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(in_ready),  32'(1));
    check("abort_busy",      32'(busy),      32'(0));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_sum",       32'(sum),       32'(0));
    check("abort_cout",      32'(cout),      32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_out_after_abort", 32'(out_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    do_op(8'h01, 8'h01, 1'b0, 0);

    do_op(8'h7F, 8'h01, 1'b0, 0);
    do_op(8'h80, 8'h80, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);

    for (int i = 0; i < 8; i++)
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), (i % 3 == 2) ? 2 : 0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
